// File: rtl/cpu_fetch_pkg.sv
// Shared control-state and opcode encodings used by the fetch stage and cpu_control.
package cpu_fetch_pkg;

    typedef enum logic [3:0] {
        STATE_FETCH_PC   = 4'h0,
        STATE_FETCH_INST = 4'h1,
        STATE_LOAD_ADDR  = 4'h2,
        STATE_LDI        = 4'h3,
        STATE_JUMP       = 4'h4,
        STATE_OUT_A      = 4'h5,
        STATE_RAM_A      = 4'h6,
        STATE_RAM_B      = 4'h7,
        STATE_STORE_A    = 4'h8,
        STATE_ALU_OP     = 4'h9,
        STATE_HALT       = 4'hA,
        STATE_NEXT       = 4'hB
    } state_e;

    localparam logic [7:0] OP_LDI = 8'h10;
    localparam logic [7:0] OP_JMP = 8'h20;
    localparam logic [7:0] OP_JEZ = 8'h21;
    localparam logic [7:0] OP_JNZ = 8'h22;
    localparam logic [7:0] OP_HLT = 8'hFF;

endpackage

// File: rtl/cpu_jump_cond.sv
// Combinational jump resolver: exact opcode match against the jump opcodes and the zero flag.
module cpu_jump_cond
    import cpu_fetch_pkg::*;
(
    input  logic [7:0] opcode,
    input  logic       zero_flag,
    output logic       taken
);

    always_comb begin
        // NOTE: default assignment first so every path drives taken and no latch is inferred.
        taken = 1'b0;
        case (opcode)
            OP_JMP:  taken = 1'b1;
            OP_JEZ:  taken = zero_flag;
            OP_JNZ:  taken = ~zero_flag;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_fetch.sv
// Fetch/sequencing stage: PC, MAR, IR and operand registers driven by the control state.
// Optional breakpoint halt on PC match is enabled by defining CPU_FETCH_BREAKPOINT_EN.
module cpu_fetch
    import cpu_fetch_pkg::*;
#(
    parameter logic [7:0] PC_RESET = 8'h00
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] state,
    input  logic [7:0] mem_rdata,
    input  logic       zero_flag,
    input  logic [7:0] bp_addr,
    output logic [7:0] mem_addr,
    output logic [7:0] opcode,
    output logic [7:0] operand,
    output logic [7:0] pc,
    output logic       cycle_reset,
    output logic       halted
);

    logic jump_taken;
    logic next_seen;   // NEXT was present on the previous acting edge

    cpu_jump_cond u_jump_cond (
        .opcode    (opcode),
        .zero_flag (zero_flag),
        .taken     (jump_taken)
    );

`ifndef CPU_FETCH_BREAKPOINT_EN
    logic unused_bp;
    assign unused_bp = ^bp_addr;
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc          <= PC_RESET;
            mem_addr    <= 8'h00;
            opcode      <= 8'h00;
            operand     <= 8'h00;
            cycle_reset <= 1'b0;
            halted      <= 1'b0;
            next_seen   <= 1'b0;
        end else if (!halted) begin
            cycle_reset <= 1'b0;
            next_seen   <= (state == STATE_NEXT);
            case (state)
                STATE_FETCH_PC: begin
`ifdef CPU_FETCH_BREAKPOINT_EN
                    if (pc == bp_addr) begin
                        halted <= 1'b1;
                    end else begin
                        mem_addr <= pc;
                        pc       <= pc + 8'd1;
                    end
`else
                    mem_addr <= pc;
                    pc       <= pc + 8'd1;
`endif
                end
                STATE_FETCH_INST: opcode <= mem_rdata;
                STATE_LOAD_ADDR: begin
                    operand  <= mem_rdata;
                    mem_addr <= mem_rdata;
                end
                STATE_LDI: operand <= mem_rdata;
                STATE_JUMP: begin
                    operand <= mem_rdata;
                    if (jump_taken) pc <= mem_rdata;
                end
                STATE_HALT: halted <= 1'b1;
                // A held NEXT yields a single pulse, never a level.
                STATE_NEXT: cycle_reset <= ~next_seen;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_fetch.sv
// Self-checking bench for cpu_fetch: table-driven vectors plus reset/halt/breakpoint sequences.
module tb_cpu_fetch;
    import cpu_fetch_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] state;
    logic [7:0] mem_rdata;
    logic       zero_flag;
    logic [7:0] bp_addr;
    logic [7:0] mem_addr;
    logic [7:0] opcode;
    logic [7:0] operand;
    logic [7:0] pc;
    logic       cycle_reset;
    logic       halted;

    int n_checks = 0;
    int n_errors = 0;

    cpu_fetch #(.PC_RESET(8'h00)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .state       (state),
        .mem_rdata   (mem_rdata),
        .zero_flag   (zero_flag),
        .bp_addr     (bp_addr),
        .mem_addr    (mem_addr),
        .opcode      (opcode),
        .operand     (operand),
        .pc          (pc),
        .cycle_reset (cycle_reset),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] st;
        logic [7:0] rd;
        logic       zf;
        logic [7:0] e_pc;
        logic [7:0] e_ma;
        logic [7:0] e_op;
        logic [7:0] e_opd;
        logic       e_cr;
        logic       e_h;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] st, input logic [7:0] rd, input logic zf,
                                input logic [7:0] e_pc, input logic [7:0] e_ma,
                                input logic [7:0] e_op, input logic [7:0] e_opd,
                                input logic e_cr, input logic e_h);
        vec_t v;
        v.st = st; v.rd = rd; v.zf = zf;
        v.e_pc = e_pc; v.e_ma = e_ma; v.e_op = e_op; v.e_opd = e_opd;
        v.e_cr = e_cr; v.e_h = e_h;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] e_pc, input logic [7:0] e_ma,
                             input logic [7:0] e_op, input logic [7:0] e_opd,
                             input logic e_cr, input logic e_h);
        check({tag, ".pc"},          pc,                 e_pc);
        check({tag, ".mem_addr"},    mem_addr,           e_ma);
        check({tag, ".opcode"},      opcode,             e_op);
        check({tag, ".operand"},     operand,            e_opd);
        check({tag, ".cycle_reset"}, {7'b0, cycle_reset}, {7'b0, e_cr});
        check({tag, ".halted"},      {7'b0, halted},     {7'b0, e_h});
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit after the next one.
    task automatic step(input logic [3:0] st, input logic [7:0] rd, input logic zf);
        state     = st;
        mem_rdata = rd;
        zero_flag = zf;
        @(posedge clk);
        #1;
    endtask

    task automatic run_table(input string prefix);
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].st, vecs[i].rd, vecs[i].zf);
            check_all($sformatf("%s%0d", prefix, i), vecs[i].e_pc, vecs[i].e_ma,
                      vecs[i].e_op, vecs[i].e_opd, vecs[i].e_cr, vecs[i].e_h);
        end
        vecs.delete();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check_all("async_reset", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n   = 1'b0;
        state     = STATE_OUT_A;
        mem_rdata = 8'h00;
        zero_flag = 1'b0;
        bp_addr   = 8'hAA;
        @(posedge clk);
        #1;
        check_all("reset", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        reset_n = 1'b1;

        // Main instruction flow: fetch, load, NEXT pulse, conditional jumps, wrap, LDI, holds.
        //              state             rd     zf    pc     ma     op     opd    cr    h
        vecs.push_back(mk(STATE_FETCH_PC,   8'h00, 1'b0, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0));
        vecs.push_back(mk(STATE_FETCH_INST, 8'h3A, 1'b0, 8'h01, 8'h00, 8'h3A, 8'h00, 1'b0, 1'b0));
        vecs.push_back(mk(STATE_ALU_OP,     8'hFF, 1'b1, 8'h01, 8'h00, 8'h3A, 8'h00, 1'b0, 1'b0));
        vecs.push_back(mk(STATE_LOAD_ADDR,  8'h7E, 1'b0, 8'h01, 8'h7E, 8'h3A, 8'h7E, 1'b0, 1'b0));
        vecs.push_back(mk(STATE_NEXT,       8'h00, 1'b0, 8'h01, 8'h7E, 8'h3A, 8'h7E, 1'b1, 1'b0));
        vecs.push_back(mk(STATE_NEXT,       8'h00, 1'b0, 8'h01, 8'h7E, 8'h3A, 8'h7E, 1'b0, 1'b0));
        vecs.push_back(mk(STATE_OUT_A,      8'h00, 1'b0, 8'h01, 8'h7E, 8'h3A, 8'h7E, 1'b0, 1'b0));
        vecs.push_back(mk(STATE_FETCH_PC,   8'h00, 1'b0, 8'h02, 8'h01, 8'h3A, 8'h7E, 1'b0, 1'b0));
        vecs.push_back(mk(STATE_FETCH_INST, OP_JEZ, 1'b0, 8'h02, 8'h01, OP_JEZ, 8'h7E, 1'b0, 1'b0));
        vecs.push_back(mk(STATE_JUMP,       8'h20, 1'b1, 8'h20, 8'h01, OP_JEZ, 8'h20, 1'b0, 1'b0));
        vecs.push_back(mk(STATE_JUMP,       8'h30, 1'b0, 8'h20, 8'h01, OP_JEZ, 8'h30, 1'b0, 1'b0));
        vecs.push_back(mk(STATE_FETCH_INST, OP_JNZ, 1'b0, 8'h20, 8'h01, OP_JNZ, 8'h30, 1'b0, 1'b0));
        vecs.push_back(mk(STATE_JUMP,       8'h40, 1'b0, 8'h40, 8'h01, OP_JNZ, 8'h40, 1'b0, 1'b0));
        vecs.push_back(mk(STATE_JUMP,       8'h50, 1'b1, 8'h40, 8'h01, OP_JNZ, 8'h50, 1'b0, 1'b0));
        vecs.push_back(mk(STATE_FETCH_INST, OP_JMP, 1'b0, 8'h40, 8'h01, OP_JMP, 8'h50, 1'b0, 1'b0));
        vecs.push_back(mk(STATE_JUMP,       8'hFF, 1'b0, 8'hFF, 8'h01, OP_JMP, 8'hFF, 1'b0, 1'b0));
        vecs.push_back(mk(STATE_FETCH_PC,   8'h00, 1'b0, 8'h00, 8'hFF, OP_JMP, 8'hFF, 1'b0, 1'b0));
        vecs.push_back(mk(STATE_LDI,        8'h5C, 1'b0, 8'h00, 8'hFF, OP_JMP, 8'h5C, 1'b0, 1'b0));
        vecs.push_back(mk(STATE_FETCH_INST, OP_LDI, 1'b0, 8'h00, 8'hFF, OP_LDI, 8'h5C, 1'b0, 1'b0));
        vecs.push_back(mk(STATE_JUMP,       8'h33, 1'b1, 8'h00, 8'hFF, OP_LDI, 8'h33, 1'b0, 1'b0));
        vecs.push_back(mk(4'hF,             8'h99, 1'b1, 8'h00, 8'hFF, OP_LDI, 8'h33, 1'b0, 1'b0));
        vecs.push_back(mk(STATE_STORE_A,    8'h99, 1'b0, 8'h00, 8'hFF, OP_LDI, 8'h33, 1'b0, 1'b0));
        run_table("flow");

        // Halt is sticky: every later state is ignored and cycle_reset stays low.
        vecs.push_back(mk(STATE_HALT,       8'h00, 1'b0, 8'h00, 8'hFF, OP_LDI, 8'h33, 1'b0, 1'b1));
        vecs.push_back(mk(STATE_FETCH_PC,   8'h44, 1'b0, 8'h00, 8'hFF, OP_LDI, 8'h33, 1'b0, 1'b1));
        vecs.push_back(mk(STATE_FETCH_INST, OP_JMP, 1'b0, 8'h00, 8'hFF, OP_LDI, 8'h33, 1'b0, 1'b1));
        vecs.push_back(mk(STATE_JUMP,       8'h77, 1'b0, 8'h00, 8'hFF, OP_LDI, 8'h33, 1'b0, 1'b1));
        vecs.push_back(mk(STATE_NEXT,       8'h00, 1'b0, 8'h00, 8'hFF, OP_LDI, 8'h33, 1'b0, 1'b1));
        vecs.push_back(mk(STATE_LOAD_ADDR,  8'h12, 1'b0, 8'h00, 8'hFF, OP_LDI, 8'h33, 1'b0, 1'b1));
        run_table("halt");

        // Asynchronous reset pulse mid-run clears everything before the next edge.
        state = STATE_FETCH_PC;
        do_reset();

        // PC breakpoint: bring pc to 05, then FETCH_PC with bp_addr = 05.
        bp_addr = 8'h05;
        step(STATE_FETCH_INST, OP_JMP, 1'b0);
        check_all("bp_setup_inst", 8'h00, 8'h00, OP_JMP, 8'h00, 1'b0, 1'b0);
        step(STATE_JUMP, 8'h05, 1'b0);
        check_all("bp_setup_jump", 8'h05, 8'h00, OP_JMP, 8'h05, 1'b0, 1'b0);
        step(STATE_FETCH_PC, 8'h00, 1'b0);
`ifdef CPU_FETCH_BREAKPOINT_EN
        check_all("bp_hit", 8'h05, 8'h00, OP_JMP, 8'h05, 1'b0, 1'b1);
        step(STATE_FETCH_PC, 8'h00, 1'b0);
        check_all("bp_frozen", 8'h05, 8'h00, OP_JMP, 8'h05, 1'b0, 1'b1);
`else
        check_all("bp_ignored", 8'h06, 8'h05, OP_JMP, 8'h05, 1'b0, 1'b0);
        step(STATE_FETCH_PC, 8'h00, 1'b0);
        check_all("bp_ignored2", 8'h07, 8'h06, OP_JMP, 8'h05, 1'b0, 1'b0);
`endif

        // A lone NEXT after reset also pulses for exactly one cycle.
        step(STATE_NEXT, 8'h00, 1'b0);
        check("next_only.cycle_reset", {7'b0, cycle_reset}, {7'b0, ~halted});
        step(STATE_OUT_A, 8'h00, 1'b0);
        check("next_only_end.cycle_reset", {7'b0, cycle_reset}, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cpu_fetch.md
# cpu_fetch

Upstream fetch and sequencing stage for `cpu_control`. It owns the program counter (PC), memory address register (MAR), instruction register (IR) and operand register. It acts on the 4-bit `state` from `cpu_control` to fetch opcodes and operands, resolve jumps and latch halt. It drives `opcode` into `cpu_control` and pulses `cycle_reset` back to it at the end of each instruction.

## Interface
- `PC_RESET`, 8'h00, PC value loaded on reset.
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `state`  in  4  current control state, using the `STATE_*` encoding.
- `mem_rdata`  in  8  RAM read data; RAM is asynchronous-read at `mem_addr`.
- `zero_flag`  in  1  ALU zero flag, used only in `STATE_JUMP`.
- `bp_addr`  in  8  breakpoint address (used only with `BREAKPOINT_EN`).
- `mem_addr`  out  8  MAR contents.
- `opcode`  out  8  IR contents, to `cpu_control`.
- `operand`  out  8  last fetched operand byte (LDI immediate or address).
- `pc`  out  8  program counter.
- `cycle_reset`  out  1  one-cycle pulse to `cpu_control.reset_cycle`.
- `halted`  out  1  sticky halt indicator.

## Operation
- Async reset (`reset_n`=0) sets:
  - `pc`=`PC_RESET`
  - `mem_addr`, `opcode`, `operand` = 0
  - `cycle_reset`=0, `halted`=0
- When `halted`=1, all registers freeze regardless of `state` until reset. `cycle_reset` stays 0.
- Action on each rising edge, decoded from `state`:
  - `STATE_FETCH_PC`: `mem_addr`←`pc`, `pc`←`pc`+1 (8-bit, FF wraps to 00).
  - `STATE_FETCH_INST`: `opcode`←`mem_rdata`.
  - `STATE_LOAD_ADDR`: `operand`←`mem_rdata`, `mem_addr`←`mem_rdata`.
  - `STATE_LDI`: `operand`←`mem_rdata`; MAR unchanged.
  - `STATE_JUMP`: `operand`←`mem_rdata`. `pc`←`mem_rdata` if the jump is taken:
    - `OP_JMP`: always taken.
    - `OP_JEZ`: taken when `zero_flag`=1.
    - `OP_JNZ`: taken when `zero_flag`=0.
    - Otherwise `pc` unchanged.
  - `STATE_HALT`: `halted`←1.
  - `STATE_NEXT`: `cycle_reset`←1 for exactly one cycle.
  - All other states (`OUT_A`, `RAM_A`, `RAM_B`, `STORE_A`, `ALU_OP`, unknown codes): hold all registers.
- `cycle_reset` is 0 in every cycle not following a `STATE_NEXT` edge. If `STATE_NEXT` persists for two consecutive edges, `cycle_reset` goes 1 then 0 (edge pulse, never a level).
- Opcode comparison for jumps uses exact match on `opcode`, not the LDI class mask.

## Timing
- All outputs are registered. No combinational path from `state` or `mem_rdata` to any output.
- The action for a `state` value takes effect on the first rising edge at which that value is present. Results are visible at the outputs one cycle later.
- Fetch latency: `opcode` updates 2 edges after the first `STATE_FETCH_PC` (FETCH_PC edge, then FETCH_INST edge).
- A taken jump makes the new `pc` visible in the cycle after the JUMP edge. The next `STATE_FETCH_PC` uses it.
- `cycle_reset` rises in the cycle after the NEXT edge, so `cpu_control` restarts at cycle 0 for the following instruction.
- Reset deasserted mid-instruction: outputs are already at reset values. The first edge with `reset_n`=1 acts on whatever `state` is present.

## Configuration
- `CPU_FETCH_BREAKPOINT_EN` defined:
  - On a `STATE_FETCH_PC` edge where `pc`==`bp_addr`, `halted`←1.
  - `pc` and `mem_addr` are NOT updated on that edge.
  - If the breakpoint matches and `state` is also `STATE_HALT`-equivalent, the result is the same: halted.
- Not defined: `bp_addr` is ignored, with no compare logic; `halted` is set only by `STATE_HALT`.

## Structure
- `STATE_*` and `OP_*` codes come from the shared parameters include. Do not redefine them locally.
- A jump-condition evaluator is a natural sub-module, `cpu_jump_cond`: opcode and `zero_flag` in, `taken` out, purely combinational.
- Register file (PC/MAR/IR/operand) and `cycle_reset` pulse logic live in `cpu_fetch`.

## Test plan
- Reset, then FETCH_PC, FETCH_INST with RAM[00]=8'h3A → `mem_addr`=00, `pc`=01, `opcode`=3A, `cycle_reset`=0.
- `pc`=FF, FETCH_PC → `mem_addr`=FF, `pc`=00.
- `opcode`=`OP_JEZ`, JUMP with `mem_rdata`=8'h20:
  - `zero_flag`=1 → `pc`=20.
  - `zero_flag`=0 → `pc` unchanged.
  - Repeat with `OP_JNZ` → inverse results.
- LOAD_ADDR with `mem_rdata`=8'h7E → `operand`=7E, `mem_addr`=7E. Then NEXT → `cycle_reset` high exactly one cycle.
- HALT → `halted`=1. Subsequent FETCH_PC/JUMP edges leave `pc`, `opcode` frozen. Pulse `reset_n` low → all outputs 0.
- With `CPU_FETCH_BREAKPOINT_EN`, `bp_addr`=05, `pc`=05, FETCH_PC → `halted`=1, `pc`=05, `mem_addr` unchanged. Without the macro → `pc`=06.
